// File: rtl/write_back_pkg.sv
// write_back_pkg: shared pipeline types, flag bit positions and write-back state encoding
package write_back_pkg;
    typedef logic [4:0]  regind_t;
    typedef logic [31:0] regval_t;
    localparam int FLAG_CARRY    = 3;
    localparam int FLAG_NEGATIVE = 2;
    localparam int FLAG_OVERFLOW = 1;
    localparam int FLAG_ZERO     = 0;
    typedef enum logic [1:0] {IDLE, UPPER, STORE} wb_state_t;
endpackage

// File: rtl/write_back.sv
// write_back: final pipeline stage committing register, flag and store effects
module write_back
    import write_back_pkg::*;
#(
    parameter int REG_BITS  = 5,
    parameter int DATA_BITS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_hold,
    input  logic [31:0]          in_pc,
    input  logic [REG_BITS-1:0]  in_destination_register,
    input  logic                 in_is_writing_memory,
    input  logic [3:0]           in_flags,
    input  logic [DATA_BITS-1:0] in_destination_value,
    input  logic                 in_has_upper_value,
    input  logic [DATA_BITS-1:0] in_upper_value,
    input  logic [DATA_BITS-1:0] in_adjustment_value,
    input  logic                 in_has_flushed,
    output logic [REG_BITS-1:0]  rd_index,
    input  logic [DATA_BITS-1:0] rd_value,
    output logic                 rf_we,
    output logic [REG_BITS-1:0]  rf_index,
    output logic [DATA_BITS-1:0] rf_value,
    output logic                 flags_we,
    output logic [3:0]           flags_value,
    output logic                 mem_write,
    output logic [DATA_BITS-1:0] mem_address,
    output logic [DATA_BITS-1:0] mem_data,
    input  logic                 mem_wait,
    output logic                 retire_valid,
    output logic [31:0]          retire_pc
);
    wb_state_t             state;
    logic [DATA_BITS-1:0]  upper_q;
    logic [REG_BITS-1:0]   next_index;
    logic                  take;
    assign take       = in_valid && state == IDLE && !in_has_flushed;
    assign in_hold    = !reset && in_valid && (state != IDLE ||
                        (!in_has_flushed && (in_has_upper_value || in_is_writing_memory)));
    assign rd_index   = in_destination_register;
    // rf_index still holds the lower word's index while in UPPER
    assign next_index = rf_index + 1'b1;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            upper_q      <= '0;
            rf_we        <= 1'b0;
            rf_index     <= '0;
            rf_value     <= '0;
            flags_we     <= 1'b0;
            flags_value  <= '0;
            mem_write    <= 1'b0;
            mem_address  <= '0;
            mem_data     <= '0;
            retire_valid <= 1'b0;
            retire_pc    <= '0;
        end else begin
            rf_we        <= 1'b0;
            flags_we     <= 1'b0;
            retire_valid <= 1'b0;
            if (state == UPPER) begin
                rf_we        <= next_index != '0;
                rf_index     <= next_index;
                rf_value     <= upper_q;
                retire_valid <= 1'b1;
                state        <= IDLE;
            end else if (state == STORE) begin
                if (!mem_wait) begin
                    mem_write    <= 1'b0;
                    retire_valid <= 1'b1;
                    state        <= IDLE;
                end
            end else if (take) begin
                flags_we    <= 1'b1;
                flags_value <= in_flags;
                retire_pc   <= in_pc;
                if (in_is_writing_memory) begin
                    mem_write   <= 1'b1;
                    mem_address <= rd_value + in_adjustment_value;
                    mem_data    <= in_destination_value;
                    state       <= STORE;
                end else begin
                    rf_we        <= in_destination_register != '0;
                    rf_index     <= in_destination_register;
                    rf_value     <= in_destination_value;
                    upper_q      <= in_upper_value;
                    retire_valid <= !in_has_upper_value;
                    state        <= in_has_upper_value ? UPPER : IDLE;
                end
            end
        end
    end
endmodule
